program_sequencer: RTL and testbench
====================================

// Module: program_sequencer
// PURPOSE
//  Parametrised program sequencer for the bus-based CPU: holds the program address, advances it,
//  and adds unconditional/conditional jumps, CALL/RET through an internal return stack, and HALT.
//  Sits between the control unit (which supplies op, flags and enables) and the shared data bus
//  (pc_in from the bus, pc_out to the bus).
//  counter always shows the live address for the front panel.
// PARAMETERS
//  AW     4  address width in bits; the PC wraps modulo 2**AW
//  DEPTH  4  return-stack entries, >=1; SPW = $clog2(DEPTH+1)
// PORTS
//  CLK          in   1    clock, all state changes on posedge
//  RESET        in   1    synchronous, active-high reset
//  en           in   1    step enable; op is executed only when en=1
//  op           in   3    0 INC, 1 JMP, 2 JZ, 3 JC, 4 CALL, 5 RET, 6 HALT, 7 INC (reserved)
//  pc_in        in   AW   target address from bus (JMP/JZ/JC/CALL)
//  flag_z       in   1    zero flag, sampled with op
//  flag_c       in   1    carry flag, sampled with op
//  oe           in   1    request to drive the PC onto the bus
//  resume       in   1    leave HALT
//  counter      out  AW   live PC register
//  pc_out       out  AW   registered bus copy of the PC
//  pc_out_vld   out  1    pc_out was captured in the previous cycle
//  sp           out  SPW  stack occupancy, 0..DEPTH
//  halted       out  1    state == HALT
//  fault        out  1    state == FAULT (sticky)
// BEHAVIOUR
//  Reset: counter=0, pc_out=0, pc_out_vld=0, sp=0, state=RUN, halted=0, fault=0.
//    Stack contents are don't-care.
//  States and transitions:
//    RUN   -> HALT  when en & op==HALT.
//    RUN   -> FAULT on CALL with sp==DEPTH, or RET with sp==0.
//    HALT  -> RUN   on resume.
//    FAULT -> (none) only RESET exits.
//    In HALT/FAULT, en and op are ignored and counter is frozen.
//  RUN with en=0: counter holds. RUN with en=1, all results visible the next cycle:
//    INC : counter <= counter+1, AW-bit wrap ((2**AW-1) -> 0).
//    JMP : counter <= pc_in.
//    JZ/JC: counter <= flag ? pc_in : counter+1.
//    CALL: push counter+1 (wrapped), counter <= pc_in, sp+1.
//          Overflow: no push, counter holds, FAULT.
//    RET : counter <= top, sp-1.
//          Underflow: counter holds, FAULT.
//    HALT: counter holds.
//  oe is honoured in every state, independent of en. pc_out <= counter (the pre-update value)
//    and pc_out_vld=1 the next cycle. With oe=0, pc_out holds and pc_out_vld=0.
//  An oe coinciding with JMP/CALL outputs the old PC, never pc_in.
//  resume while en & op==HALT in the same cycle: not possible (already RUN), so HALT wins.
//  resume in RUN/FAULT: ignored.
//  RESET mid-CALL or mid-RET wins: the stack is emptied (sp=0) and no push/pop takes effect.
//  Stack is LIFO. A push and a pop never occur in the same cycle (single op per cycle).
// STRUCTURE
//  Shared package cpu_seq_pkg: op encodings (OP_INC..OP_HALT), state encodings (ST_RUN,
//    ST_HALT, ST_FAULT), and a DEPTH-to-SPW helper function.
//  Sub-module return_stack #(AW,DEPTH):
//    ports: push, pop, din, dout, sp, full, empty.
//    Synchronous LIFO with combinational top-of-stack read.
//  The sequencer owns the state machine, next-PC mux, fault detection and bus register.
// TESTING
//  1 Reset, then en=1, op=INC for 17 cycles with AW=4
//    -> counter 1..15, 0, 1; fault=0.
//  2 counter=3: JZ pc_in=9, z=0 -> 4; then JZ pc_in=9, z=1 -> 9; JC pc_in=2, c=1 -> 2.
//  3 counter=5: CALL pc_in=12 -> counter=12, sp=1; then RET -> counter=6, sp=0.
//    Also CALL at counter=15 -> RET yields 0 (wrap).
//  4 DEPTH=4: 5 CALLs -> 5th sets fault=1, sp=4, counter unchanged.
//    Subsequent INC/oe: counter frozen, pc_out still updates.
//    RESET -> all reset values.
//  5 HALT at counter=7 -> halted=1, INC ignored 3 cycles (counter=7).
//    resume -> RUN; next INC -> 8.
//  6 oe=1 with JMP pc_in=10 at counter=4 -> next cycle pc_out=4, pc_out_vld=1, counter=10.
//    Then oe=0 -> pc_out_vld=0.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// rtl/cpu_seq_pkg.sv - shared op/state encodings and stack-pointer sizing for the program sequencer
package cpu_seq_pkg;

    localparam logic [2:0] OP_INC  = 3'd0;
    localparam logic [2:0] OP_JMP  = 3'd1;
    localparam logic [2:0] OP_JZ   = 3'd2;
    localparam logic [2:0] OP_JC   = 3'd3;
    localparam logic [2:0] OP_CALL = 3'd4;
    localparam logic [2:0] OP_RET  = 3'd5;
    localparam logic [2:0] OP_HALT = 3'd6;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_HALT  = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    // Occupancy must represent 0..DEPTH inclusive.
    function automatic int sp_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/return_stack.sv
// rtl/return_stack.sv - synchronous LIFO of return addresses with combinational top-of-stack
module return_stack
    import cpu_seq_pkg::*;
#(
    parameter int AW    = 4,
    parameter int DEPTH = 4,
    localparam int SPW  = sp_width(DEPTH)
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           push,
    input  logic           pop,
    input  logic [AW-1:0]  din,
    output logic [AW-1:0]  dout,
    output logic [SPW-1:0] sp,
    output logic           full,
    output logic           empty
);

    // Sized to the full pointer range so every sp value is a legal index.
    logic [AW-1:0] mem [2**SPW];

    assign full  = (sp == SPW'(DEPTH));
    assign empty = (sp == '0);
    assign dout  = mem[sp - SPW'(1)];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sp <= '0;
        end else if (push && !full) begin
            mem[sp] <= din;
            sp      <= sp + SPW'(1);
        end else if (pop && !empty) begin
            sp <= sp - SPW'(1);
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - program counter with jumps, CALL/RET stack, HALT/FAULT states and bus register
module program_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int AW    = 4,
    parameter int DEPTH = 4,
    localparam int SPW  = sp_width(DEPTH)
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           en,
    input  logic [2:0]     op,
    input  logic [AW-1:0]  pc_in,
    input  logic           flag_z,
    input  logic           flag_c,
    input  logic           oe,
    input  logic           resume,
    output logic [AW-1:0]  counter,
    output logic [AW-1:0]  pc_out,
    output logic           pc_out_vld,
    output logic [SPW-1:0] sp,
    output logic           halted,
    output logic           fault
);

    logic [1:0]    state, state_nxt;
    logic [AW-1:0] counter_nxt, pc_inc, top;
    logic          push, pop, full, empty;

    assign pc_inc = counter + AW'(1);
    assign halted = (state == ST_HALT);
    assign fault  = (state == ST_FAULT);

    return_stack #(.AW(AW), .DEPTH(DEPTH)) u_stack (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (top),
        .sp    (sp),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        counter_nxt = counter;
        state_nxt   = state;
        push        = 1'b0;
        pop         = 1'b0;
        case (state)
            ST_RUN: begin
                if (en) begin
                    case (op)
                        OP_JMP:  counter_nxt = pc_in;
                        OP_JZ:   counter_nxt = flag_z ? pc_in : pc_inc;
                        OP_JC:   counter_nxt = flag_c ? pc_in : pc_inc;
                        OP_CALL: begin
                            if (full) begin
                                state_nxt = ST_FAULT;
                            end else begin
                                push        = 1'b1;
                                counter_nxt = pc_in;
                            end
                        end
                        OP_RET: begin
                            if (empty) begin
                                state_nxt = ST_FAULT;
                            end else begin
                                pop         = 1'b1;
                                counter_nxt = top;
                            end
                        end
                        OP_HALT: state_nxt = ST_HALT;
                        default: counter_nxt = pc_inc;
                    endcase
                end
            end
            ST_HALT: begin
                if (resume) state_nxt = ST_RUN;
            end
            default: ;
        endcase
    end

    // The bus copy always takes the pre-update PC, whatever the op does this cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= ST_RUN;
            counter    <= '0;
            pc_out     <= '0;
            pc_out_vld <= 1'b0;
        end else begin
            state      <= state_nxt;
            counter    <= counter_nxt;
            pc_out_vld <= oe;
            if (oe) pc_out <= counter;
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - vector table, corner sequences and random run against a queue-based model
module tb_program_sequencer;

    localparam int AW    = 4;
    localparam int DEPTH = 4;
    localparam int SPW   = $clog2(DEPTH + 1);
    localparam int MOD   = 2 ** AW;

    logic           CLK = 1'b0;
    logic           RESET = 1'b1;
    logic           en = 1'b0;
    logic [2:0]     op = 3'd0;
    logic [AW-1:0]  pc_in = '0;
    logic           flag_z = 1'b0;
    logic           flag_c = 1'b0;
    logic           oe = 1'b0;
    logic           resume = 1'b0;
    logic [AW-1:0]  counter;
    logic [AW-1:0]  pc_out;
    logic           pc_out_vld;
    logic [SPW-1:0] sp;
    logic           halted;
    logic           fault;

    program_sequencer #(.AW(AW), .DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .en         (en),
        .op         (op),
        .pc_in      (pc_in),
        .flag_z     (flag_z),
        .flag_c     (flag_c),
        .oe         (oe),
        .resume     (resume),
        .counter    (counter),
        .pc_out     (pc_out),
        .pc_out_vld (pc_out_vld),
        .sp         (sp),
        .halted     (halted),
        .fault      (fault)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Behavioural model: plain integers and a queue used as the return stack.
    int m_pc, m_pc_out, m_vld, m_halt, m_fault;
    int m_stack[$];

    typedef struct {
        logic       en;
        logic [2:0] op;
        int         pc_in;
        logic       z, c, oe, resume;
        int         counter, sp, halted, pc_out, vld;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model(input logic r, e, input logic [2:0] o, input int pi,
                         input logic z, c, oe_i, res);
        if (r) begin
            m_pc = 0; m_pc_out = 0; m_vld = 0; m_halt = 0; m_fault = 0;
            m_stack.delete();
            return;
        end
        if (oe_i) begin m_pc_out = m_pc; m_vld = 1; end
        else m_vld = 0;
        if (m_fault) begin
        end else if (m_halt) begin
            if (res) m_halt = 0;
        end else if (e) begin
            case (o)
                3'd1: m_pc = pi;
                3'd2: m_pc = z ? pi : (m_pc + 1) % MOD;
                3'd3: m_pc = c ? pi : (m_pc + 1) % MOD;
                3'd4: if (m_stack.size() == DEPTH) m_fault = 1;
                      else begin m_stack.push_back((m_pc + 1) % MOD); m_pc = pi; end
                3'd5: if (m_stack.size() == 0) m_fault = 1;
                      else m_pc = m_stack.pop_back();
                3'd6: m_halt = 1;
                default: m_pc = (m_pc + 1) % MOD;
            endcase
        end
    endtask

    task automatic step(input logic r, e, input logic [2:0] o, input int pi,
                        input logic z, c, oe_i, res);
        RESET = r; en = e; op = o; pc_in = AW'(pi);
        flag_z = z; flag_c = c; oe = oe_i; resume = res;
        @(posedge CLK);
        #1;
        model(r, e, o, pi, z, c, oe_i, res);
        chk("model counter", int'(counter), m_pc);
        chk("model sp", int'(sp), m_stack.size());
        chk("model halted", int'(halted), m_halt);
        chk("model fault", int'(fault), m_fault);
        chk("model pc_out_vld", int'(pc_out_vld), m_vld);
        if (m_vld == 1) chk("model pc_out", int'(pc_out), m_pc_out);
    endtask

    task automatic add(input logic e, input logic [2:0] o, input int pi, input logic z, c, oe_i, res,
                       input int ec, es, eh, epo, ev);
        vec_t v;
        v.en = e; v.op = o; v.pc_in = pi; v.z = z; v.c = c; v.oe = oe_i; v.resume = res;
        v.counter = ec; v.sp = es; v.halted = eh; v.pc_out = epo; v.vld = ev;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 3'd4, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset counter", int'(counter), 0);
        chk("reset pc_out", int'(pc_out), 0);
        chk("reset pc_out_vld", int'(pc_out_vld), 0);
        chk("reset sp", int'(sp), 0);
        chk("reset halted", int'(halted), 0);
        chk("reset fault", int'(fault), 0);
    endtask

    initial begin
        // Test 1: 17 increments wrap through zero.
        for (int i = 1; i <= 17; i++) add(1, 0, 0, 0, 0, 0, 0, i % MOD, 0, 0, 0, 0);
        // Test 2: conditional jumps.
        add(1, 1, 3, 0, 0, 0, 0, 3, 0, 0, 0, 0);
        add(1, 2, 9, 0, 0, 0, 0, 4, 0, 0, 0, 0);
        add(1, 2, 9, 1, 0, 0, 0, 9, 0, 0, 0, 0);
        add(1, 3, 2, 0, 1, 0, 0, 2, 0, 0, 0, 0);
        add(1, 3, 7, 0, 0, 0, 0, 3, 0, 0, 0, 0);
        // Test 3: CALL/RET and return-address wrap.
        add(1, 1, 5, 0, 0, 0, 0, 5, 0, 0, 0, 0);
        add(1, 4, 12, 0, 0, 0, 0, 12, 1, 0, 0, 0);
        add(1, 5, 0, 0, 0, 0, 0, 6, 0, 0, 0, 0);
        add(1, 1, 15, 0, 0, 0, 0, 15, 0, 0, 0, 0);
        add(1, 4, 3, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        add(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Test 5: HALT freezes, resume returns to RUN.
        add(1, 1, 7, 0, 0, 0, 0, 7, 0, 0, 0, 0);
        add(1, 6, 0, 0, 0, 0, 0, 7, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 0, 7, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0);
        // Test 6: oe with JMP publishes the old PC.
        add(1, 1, 4, 0, 0, 0, 0, 4, 0, 0, 0, 0);
        add(1, 1, 10, 0, 0, 1, 0, 10, 0, 0, 4, 1);
        add(0, 0, 0, 0, 0, 0, 0, 10, 0, 0, 4, 0);

        do_reset();
        foreach (vecs[i]) begin
            step(1'b0, vecs[i].en, vecs[i].op, vecs[i].pc_in, vecs[i].z, vecs[i].c,
                 vecs[i].oe, vecs[i].resume);
            chk($sformatf("vec%0d counter", i), int'(counter), vecs[i].counter);
            chk($sformatf("vec%0d sp", i), int'(sp), vecs[i].sp);
            chk($sformatf("vec%0d halted", i), int'(halted), vecs[i].halted);
            chk($sformatf("vec%0d fault", i), int'(fault), 0);
            chk($sformatf("vec%0d pc_out", i), int'(pc_out), vecs[i].pc_out);
            chk($sformatf("vec%0d pc_out_vld", i), int'(pc_out_vld), vecs[i].vld);
        end

        // Test 4: overflow on the fifth CALL, then frozen until reset.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3'd4, 5 + i, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("full sp", int'(sp), 4);
        step(1'b0, 1'b1, 3'd4, 9, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("overflow fault", int'(fault), 1);
        chk("overflow sp", int'(sp), 4);
        chk("overflow counter", int'(counter), 8);
        step(1'b0, 1'b1, 3'd0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("fault frozen counter", int'(counter), 8);
        chk("fault pc_out", int'(pc_out), 8);
        chk("fault pc_out_vld", int'(pc_out_vld), 1);
        chk("fault sticky", int'(fault), 1);
        do_reset();

        // Underflow: RET on empty stack.
        step(1'b0, 1'b1, 3'd5, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("underflow fault", int'(fault), 1);
        chk("underflow counter", int'(counter), 0);
        do_reset();

        // Random run; fault is sticky so reset is re-applied now and then.
        for (int n = 0; n < 3000; n++) begin
            logic r;
            r = (m_fault == 1 && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0;
            step(r, $urandom_range(0, 9) != 0, 3'($urandom_range(0, 7)),
                 int'($urandom_range(0, MOD - 1)), 1'($urandom), 1'($urandom),
                 1'($urandom), $urandom_range(0, 3) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
